// File: rtl/audio_frame_capture.sv
// Packs N consecutive signed samples into a frame, pulses start, then holds the frame until done (d) rises.
// Optional: define AUDIO_FRAME_DROP_COUNT_EN to add a saturating drop_count output.
module audio_frame_capture #(
  parameter int unsigned N  = 100,
  parameter int unsigned W  = 32,
  parameter int unsigned CW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     in_sample,
  output logic [N*W-1:0]   frame_data,
  output logic             start,
  input  logic             d,
  output logic             busy,
  output logic [CW-1:0]    frame_count
`ifdef AUDIO_FRAME_DROP_COUNT_EN
  ,
  output logic [CW-1:0]    drop_count
`endif
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  buf_q [N];
  logic          d_q;
  logic          wr_en;
  logic          done;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (idx_q == IW'(N - 1)) begin
            idx_d   = '0;
            state_d = LAUNCH;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        // Only a fresh rising edge of d completes the frame; a level held from before is ignored.
        if (d && !d_q) begin
          done    = 1'b1;
          idx_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // start/busy are registered from the next state so they align exactly with LAUNCH/WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      idx_q       <= '0;
      d_q         <= 1'b0;
      start       <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d_q     <= d;
      start   <= (state_d == LAUNCH);
      busy    <= (state_d != FILL);
      if (done) begin
        frame_count <= frame_count + CW'(1);
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (wr_en && (idx_q == IW'(i))) begin
          buf_q[i] <= in_sample;
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign frame_data[g*W +: W] = buf_q[g];
  end

`ifdef AUDIO_FRAME_DROP_COUNT_EN
  logic drop;
  assign drop = in_valid && ((state_q == LAUNCH) || (state_q == WAIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_audio_frame_capture.sv
// Directed bench for audio_frame_capture: table-driven fill/handshake plus hand-written corner sequences.
module tb_audio_frame_capture;
  localparam int unsigned W   = 32;
  localparam int unsigned NA  = 4;
  localparam int unsigned CWA = 4;
  localparam int unsigned NB  = 100;
  localparam int unsigned CWB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              a_v, a_d, a_start, a_busy;
  logic [W-1:0]      a_s;
  logic [NA*W-1:0]   a_fd;
  logic [CWA-1:0]    a_fc;
  logic              b_v, b_d, b_start, b_busy;
  logic [W-1:0]      b_s;
  logic [NB*W-1:0]   b_fd;
  logic [CWB-1:0]    b_fc;
`ifdef AUDIO_FRAME_DROP_COUNT_EN
  logic [CWA-1:0]    a_drop;
  logic [CWB-1:0]    b_drop;
`endif

  audio_frame_capture #(.N(NA), .W(W), .CW(CWA)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_v), .in_sample(a_s),
    .frame_data(a_fd), .start(a_start), .d(a_d), .busy(a_busy),
    .frame_count(a_fc)
`ifdef AUDIO_FRAME_DROP_COUNT_EN
    , .drop_count(a_drop)
`endif
  );

  audio_frame_capture #(.N(NB), .W(W), .CW(CWB)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_v), .in_sample(b_s),
    .frame_data(b_fd), .start(b_start), .d(b_d), .busy(b_busy),
    .frame_count(b_fc)
`ifdef AUDIO_FRAME_DROP_COUNT_EN
    , .drop_count(b_drop)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wa(input int i);
    return a_fd[i*32 +: 32];
  endfunction

  function automatic logic [31:0] sb(input int i);
    if (i == 99) return 32'hFFEA_0000;
    return 32'(196608 - i * 16384);
  endfunction

  task automatic fill_a(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      a_v = 1'b1;
      a_s = base + 32'(i);
      step();
    end
    a_v = 1'b0;
  endtask

  task automatic cmp_b(input string nm, input logic [31:0] off);
    int nbad;
    nbad = 0;
    for (int i = 0; i < int'(NB); i++)
      if (b_fd[i*32 +: 32] !== sb(i) + off) nbad++;
    chk(nm, 64'(nbad), 64'd0);
  endtask

  typedef struct {
    bit          v;
    logic [31:0] s;
    bit          d;
    bit          e_start;
    bit          e_busy;
    logic [3:0]  e_fc;
    logic [31:0] e_w0;
    logic [31:0] e_w3;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 32'h0003_0000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0003_0000, 32'h0};
    tbl[1] = '{1'b1, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0003_0000, 32'h0};
    tbl[2] = '{1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0003_0000, 32'h0};
    tbl[3] = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0003_0000, 32'h0};
    tbl[4] = '{1'b1, 32'hFFE5_0000, 1'b0, 1'b1, 1'b1, 4'd0, 32'h0003_0000, 32'hFFE5_0000};
    tbl[5] = '{1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0003_0000, 32'hFFE5_0000};
    tbl[6] = '{1'b1, 32'hBBBB_BBBB, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0003_0000, 32'hFFE5_0000};
    tbl[7] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'd1, 32'h0003_0000, 32'hFFE5_0000};
    tbl[8] = '{1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b0, 4'd1, 32'h0000_0011, 32'hFFE5_0000};

    reset = 1'b0;
    a_v = 1'b0; a_d = 1'b0; a_s = '0;
    b_v = 1'b0; b_d = 1'b0; b_s = '0;
    #1;
    chk("reset start", 64'(a_start), 64'd0);
    chk("reset busy", 64'(a_busy), 64'd0);
    chk("reset frame_count", 64'(a_fc), 64'd0);
    chk("reset frame_data", 64'(a_fd === '0), 64'd1);
    step();
    step();
    reset = 1'b1;

    // Fill with a gap, launch, a dropped sample in LAUNCH and WAIT, d handshake, resume.
    for (int r = 0; r < 9; r++) begin
      a_v = tbl[r].v; a_s = tbl[r].s; a_d = tbl[r].d;
      step();
      chk($sformatf("tbl%0d start", r), 64'(a_start), 64'(tbl[r].e_start));
      chk($sformatf("tbl%0d busy", r), 64'(a_busy), 64'(tbl[r].e_busy));
      chk($sformatf("tbl%0d frame_count", r), 64'(a_fc), 64'(tbl[r].e_fc));
      chk($sformatf("tbl%0d word0", r), 64'(wa(0)), 64'(tbl[r].e_w0));
      chk($sformatf("tbl%0d word3", r), 64'(wa(3)), 64'(tbl[r].e_w3));
    end
    a_v = 1'b0; a_d = 1'b0;
    chk("tbl word1", 64'(wa(1)), 64'h0000_0000_FFFF_0000);
    chk("tbl word2", 64'(wa(2)), 64'd0);
`ifdef AUDIO_FRAME_DROP_COUNT_EN
    chk("tbl drop_count", 64'(a_drop), 64'd2);
`endif

    // Drops: 1 in LAUNCH, 10 in WAIT including the d edge.
    fill_a(32'h22, 3);
    chk("drop launch start", 64'(a_start), 64'd1);
    for (int k = 0; k < 9 + 1; k++) begin
      a_v = 1'b1; a_s = 32'hD0 + 32'(k);
      step();
      chk("drop wait busy", 64'(a_busy), 64'd1);
    end
    chk("drop frozen word0", 64'(wa(0)), 64'h11);
    chk("drop frozen word1", 64'(wa(1)), 64'h22);
    chk("drop frozen word3", 64'(wa(3)), 64'h24);
    a_d = 1'b1; a_v = 1'b1; a_s = 32'hDEAD;
    step();
    a_d = 1'b0; a_v = 1'b0;
    chk("drop d busy", 64'(a_busy), 64'd0);
    chk("drop d frame_count", 64'(a_fc), 64'd2);
`ifdef AUDIO_FRAME_DROP_COUNT_EN
    chk("drop_count after 11", 64'(a_drop), 64'd13);
`endif
    fill_a(32'h101, 4);
    chk("resume start", 64'(a_start), 64'd1);
    chk("resume word0", 64'(wa(0)), 64'h101);
    chk("resume word3", 64'(wa(3)), 64'h104);
    for (int k = 0; k < 5; k++) begin
      a_v = 1'b1; a_s = 32'hE0;
      step();
      if (k == 0) chk("start one cycle", 64'(a_start), 64'd0);
    end
    a_v = 1'b0;
`ifdef AUDIO_FRAME_DROP_COUNT_EN
    chk("drop_count saturates", 64'(a_drop), 64'd15);
`endif
    a_d = 1'b1;
    step();
    a_d = 1'b0;
    chk("sat d frame_count", 64'(a_fc), 64'd3);
    chk("sat d busy", 64'(a_busy), 64'd0);

    // Stuck-high d: must fall and rise again before the frame completes.
    a_d = 1'b1;
    fill_a(32'h201, 4);
    chk("stuck start", 64'(a_start), 64'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stuck busy held", 64'(a_busy), 64'd1);
    end
    a_d = 1'b0;
    step();
    chk("stuck d low busy", 64'(a_busy), 64'd1);
    a_d = 1'b1;
    step();
    chk("stuck rise busy", 64'(a_busy), 64'd0);
    chk("stuck rise frame_count", 64'(a_fc), 64'd4);
    step();
    step();
    chk("stuck single increment", 64'(a_fc), 64'd4);
    a_d = 1'b0;

    // N=100 frame, d raised 120 cycles after start, then a second frame.
    begin
      int early;
      int bad;
      early = 0;
      for (int i = 0; i < int'(NB); i++) begin
        b_v = 1'b1; b_s = sb(i);
        step();
        if (i < int'(NB) - 1 && b_start) early++;
      end
      b_v = 1'b0;
      chk("B early start", 64'(early), 64'd0);
      chk("B start", 64'(b_start), 64'd1);
      chk("B busy", 64'(b_busy), 64'd1);
      cmp_b("B frame1 words", 32'd0);
      bad = 0;
      for (int k = 0; k < 120; k++) begin
        b_v = 1'b1; b_s = 32'hCAFE_0000 + 32'(k);
        step();
        for (int i = 0; i < int'(NB); i++)
          if (b_fd[i*32 +: 32] !== sb(i)) bad++;
        if (b_busy !== 1'b1 || b_start !== 1'b0) bad++;
      end
      chk("B wait hold", 64'(bad), 64'd0);
      b_d = 1'b1; b_s = 32'hBAD0_0000;
      step();
      b_v = 1'b0; b_d = 1'b0;
      chk("B d busy", 64'(b_busy), 64'd0);
      chk("B d frame_count", 64'(b_fc), 64'd1);
      for (int i = 0; i < int'(NB); i++) begin
        b_v = 1'b1; b_s = sb(i) + 32'd7;
        step();
      end
      b_v = 1'b0;
      chk("B second start", 64'(b_start), 64'd1);
      cmp_b("B frame2 words", 32'd7);
    end

    // Reset during WAIT: outputs drop before any clock edge.
    fill_a(32'h301, 4);
    chk("pre-reset start", 64'(a_start), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("async reset start", 64'(a_start), 64'd0);
    chk("async reset busy", 64'(a_busy), 64'd0);
    chk("async reset frame_count", 64'(a_fc), 64'd0);
`ifdef AUDIO_FRAME_DROP_COUNT_EN
    chk("async reset drop_count", 64'(a_drop), 64'd0);
`endif
    #2 reset = 1'b1;

    // Reset mid-fill discards the partial frame.
    fill_a(32'h77, 2);
    #2 reset = 1'b0;
    #1;
    chk("midfill reset word0", 64'(wa(0)), 64'd0);
    chk("midfill reset word1", 64'(wa(1)), 64'd0);
    chk("midfill reset busy", 64'(a_busy), 64'd0);
    #2 reset = 1'b1;
    fill_a(32'h1, 3);
    chk("post-reset no early start", 64'(a_start), 64'd0);
    fill_a(32'h4, 1);
    chk("post-reset start", 64'(a_start), 64'd1);
    chk("post-reset word0", 64'(wa(0)), 64'h1);
    chk("post-reset word3", 64'(wa(3)), 64'h4);

    // frame_count wraps from 15 to 0.
    for (int k = 0; k < 16; k++) begin
      step();
      a_d = 1'b1;
      step();
      a_d = 1'b0;
      chk($sformatf("wrap frame_count k%0d", k), 64'(a_fc), 64'((k + 1) % 16));
      fill_a(32'(k * 16), 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_frame_capture.md
Name: audio_frame_capture

Overview:
- Upstream stage of `audio_min_max`.
- Receives a continuous stream of signed audio samples and packs N consecutive samples into a frame.
- Presents the frame as a flattened bus, pulses `start`, then holds the frame stable until the min/max stage reports done (`d`).
- Samples that arrive while a frame is being processed are dropped. There is no backpressure, because the ADC cannot stall.

Parameters:
- N, 100, samples per frame (must be ≥2).
- W, 32, sample width in bits, signed two's complement.
- CW, 16, width of the frame counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  a new sample is present on in_sample this cycle.
- in_sample  in  W  signed audio sample.
- frame_data  out  N*W  flattened frame; sample i occupies bits [i*W +: W]; sample 0 is the first captured.
- start  out  1  one-cycle pulse: frame_data is complete and valid.
- d  in  1  done from `audio_min_max`; only a rising edge is acted on.
- busy  out  1  high from the start pulse until d is accepted.
- frame_count  out  CW  number of frames completed (d accepted); wraps at 2^CW.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FILL, write index=0, all buffer entries=0.
  - start=0, busy=0, frame_count=0, d history register=0.
  - Outputs drop immediately, without waiting for clk.
  - Reset mid-frame or mid-WAIT discards the partial frame. No start is issued for it.
- State FILL:
  - Each edge with in_valid=1 writes in_sample, bit-exact with no sign manipulation, to buffer[idx], then idx increments.
  - When the write lands at idx=N-1: idx←0, state←LAUNCH.
  - in_valid=0 holds everything.
- State LAUNCH (exactly one cycle):
  - start=1, busy=1, state←WAIT.
  - start is registered. It is high in the cycle immediately after the edge that accepted sample N-1, giving a latency of 1 cycle from the last sample.
  - in_valid in this cycle is dropped.
- State WAIT:
  - busy=1. frame_data stays frozen, with no buffer writes.
  - All in_valid samples are dropped.
  - d is registered every cycle as d_q. A rising edge (d=1 and d_q=0) causes: state←FILL, busy←0, frame_count←frame_count+1, idx=0.
  - A d level already high on entry to WAIT is ignored until it falls and rises again.
  - A sample valid on the same edge that d rises is dropped. Capture resumes with the next in_valid.
- frame_data:
  - Driven continuously from the buffer.
  - Valid for the downstream stage from the start cycle until d is accepted.
  - During FILL it shows the partially overwritten previous frame. Consumers must not sample it there.
- frame_count:
  - Wraps from 2^CW−1 to 0 with no flag.
- Simultaneous events:
  - Reset has priority over everything.
  - d in FILL or LAUNCH is ignored, though d_q still updates.

Optional Feature:
- Macro: AUDIO_FRAME_DROP_COUNT_EN.
- Defined:
  - Adds output drop_count [CW-1:0], reset to 0.
  - Increments on every edge where in_valid=1 and state is LAUNCH or WAIT, including the edge on which d rises in WAIT.
  - Saturates at 2^CW−1, with no wrap.
  - Not cleared by frame completion.
- Undefined:
  - No drop_count port, no counter logic.
  - Dropped samples are discarded silently. All other behaviour is identical.

Test Plan:
- Frame fill, N=4, W=32:
  - Stimulus: in_valid continuous with samples 196608, −65536, 0, −1769472.
  - Response: start high for exactly the one cycle after the 4th accepted sample. frame_data[31:0]=196608 and frame_data[127:96]=−1769472. busy=1.
- Gapped input, N=4:
  - Stimulus: in_valid toggles 1,0,1,0,…
  - Response: frame contents equal to the 4 valid samples only. start one cycle after the 4th valid.
- Done handshake, N=100:
  - Stimulus: the 100 samples 196608 … −1441792. A behavioural min/max model raises d 120 cycles after start.
  - Response: frame_data is unchanged through WAIT. After the d edge: busy=0, frame_count=1. The next 100 samples form frame 2 and a second start follows.
- Stuck-high d:
  - Stimulus: hold d=1 from before the start pulse.
  - Response: the block stays in WAIT (busy=1) until d goes 0 then 1. frame_count increments once.
- Reset mid-fill, N=4:
  - Stimulus: after 2 samples, pulse reset low for 3 ns between edges.
  - Response: busy, start and frame_count are 0 immediately. The next 4 samples produce one start whose contents hold only the post-reset samples.
- Drops, with AUDIO_FRAME_DROP_COUNT_EN:
  - Stimulus: N=4; 10 in_valid cycles during WAIT, plus 1 in LAUNCH.
  - Response: drop_count=11. Capture after d begins with the first post-d sample.
- Drops, without AUDIO_FRAME_DROP_COUNT_EN:
  - Same stimulus.
  - Response: identical frame behaviour, and the bench confirms there is no drop_count port.
